sblk_act_feeder: RTL and testbench

// - Responder side of the sblk activation-load handshake: serves the per-batch act request and streams one batch with act_in_vld.
// - Sits between the global activation SRAM read port and one sblk; one request pulse = one full batch.
// - Batch length L = n_tp*n_tn*N_TILE words; batches are read back-to-back from a configured base address.

---
 rtl/sblk_act_feeder_if.sv | 24 ++
 rtl/sblk_act_feeder.sv | 166 ++++++++++++++++
 tb/tb_sblk_act_feeder.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sblk_act_feeder_if.sv
// Activation-feeder bus: sblk act handshake plus SRAM read port.
// master = feeder side, slave = sblk/SRAM side.
interface sblk_act_feeder_if #(
  parameter int WID_ACT     = 8,
  parameter int WID_SRCADDR = 12
);
  logic                   act_in_req;
  logic                   act_in_vld;
  logic [2*WID_ACT-1:0]   act_in;
  logic                   src_rd_en;
  logic [WID_SRCADDR-1:0] src_rd_addr;
  logic                   src_gnt;
  logic [2*WID_ACT-1:0]   src_rd_data;

  modport master (
    input  act_in_req, src_gnt, src_rd_data,
    output act_in_vld, act_in, src_rd_en, src_rd_addr
  );

  modport slave (
    output act_in_req, src_gnt, src_rd_data,
    input  act_in_vld, act_in, src_rd_en, src_rd_addr
  );
endinterface

// File: rtl/sblk_act_feeder.sv
// Streams one activation batch per sblk request from SRAM.
// SBLK_ACT_FEED_STALL_CNT_EN adds the stall_cnt output.
module sblk_act_feeder #(
  parameter int N_TILE      = 4,
  parameter int WID_N_TILE  = $clog2(N_TILE),
  parameter int WID_ACT     = 8,
  parameter int WID_SRCADDR = 12,
  parameter int WID_INST_TN = 3,
  parameter int WID_INST_TP = 2,
  parameter int WID_BATCH   = 6,
  parameter int RD_LAT      = 2
) (
  input  logic                   clk_l,
  input  logic                   rst_n,
  input  logic                   cfg_en,
  input  logic [WID_INST_TN-1:0] cfg_n_tn,
  input  logic [WID_INST_TP-1:0] cfg_n_tp,
  input  logic [WID_BATCH-1:0]   cfg_n_batch,
  input  logic [WID_SRCADDR-1:0] cfg_base_addr,
  sblk_act_feeder_if.master      bus,
  output logic                   status_feed,
  output logic                   err_flag
`ifdef SBLK_ACT_FEED_STALL_CNT_EN
  ,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int WID_L =
    WID_INST_TN + WID_INST_TP + WID_N_TILE;

  typedef enum logic [1:0] {
    S_IDLE, S_ARMED, S_BURST, S_DRAIN
  } state_e;

  state_e                 st_q;
  logic [WID_L-1:0]       len_q, len_d;
  logic [WID_L-1:0]       word_q, word_d;
  logic [WID_SRCADDR-1:0] addr_q, addr_d;
  logic [WID_BATCH-1:0]   nb_q, bat_q;
  logic                   pend_q, rd_en_q;
  logic                   stat_q, err_q;
  logic [RD_LAT:0]        pipe_q;
  logic [2*WID_ACT-1:0]   act_q;
  logic                   issue, last_w, last_b;
  logic                   pipe_idle, cfg_bad;

  // Issue/termination decode and next word/address.
  // The address runs linearly across batches, which
  // equals base + batch*L + word modulo the SRAM size.
  always_comb begin
    issue     = rd_en_q & bus.src_gnt;
    last_w    = issue & (word_q == len_q - 1'b1);
    last_b    = (bat_q + 1'b1) == nb_q;
    pipe_idle = ~|pipe_q[RD_LAT-1:0];
    cfg_bad   = (cfg_n_tn == '0) | (cfg_n_tp == '0)
              | (cfg_n_batch == '0);
    len_d     = WID_L'(cfg_n_tn) * WID_L'(cfg_n_tp)
              * WID_L'(N_TILE);
    word_d    = issue ? word_q + 1'b1 : word_q;
    addr_d    = issue ? addr_q + 1'b1 : addr_q;
  end

  // Control FSM, read-valid pipe and output registers.
  always_ff @(posedge clk_l) begin
    if (!rst_n) begin
      st_q    <= S_IDLE;
      len_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      nb_q    <= '0;
      bat_q   <= '0;
      pend_q  <= 1'b0;
      rd_en_q <= 1'b0;
      stat_q  <= 1'b0;
      err_q   <= 1'b0;
      pipe_q  <= '0;
      act_q   <= '0;
    end else if (cfg_en) begin
      len_q   <= len_d;
      nb_q    <= cfg_n_batch;
      word_q  <= '0;
      bat_q   <= '0;
      pend_q  <= 1'b0;
      rd_en_q <= 1'b0;
      pipe_q  <= '0;
      act_q   <= '0;
      if (cfg_bad) begin
        st_q   <= S_IDLE;
        addr_q <= '0;
        stat_q <= 1'b0;
        err_q  <= 1'b1;
      end else begin
        st_q   <= S_ARMED;
        addr_q <= cfg_base_addr;
        stat_q <= 1'b1;
        err_q  <= 1'b0;
      end
    end else begin
      pipe_q <= {pipe_q[RD_LAT-1:0], issue};
      act_q  <= pipe_q[RD_LAT-1] ? bus.src_rd_data : '0;
      word_q <= word_d;
      addr_q <= addr_d;
      unique case (st_q)
        S_IDLE: begin
          if (bus.act_in_req) err_q <= 1'b1;
        end
        S_ARMED: begin
          if (bus.act_in_req | pend_q) begin
            st_q    <= S_BURST;
            rd_en_q <= 1'b1;
            pend_q  <= 1'b0;
          end
        end
        S_BURST, S_DRAIN: begin
          if (bus.act_in_req) begin
            if (pend_q | last_b) err_q  <= 1'b1;
            else                 pend_q <= 1'b1;
          end
          if (st_q == S_BURST && last_w) begin
            st_q    <= S_DRAIN;
            rd_en_q <= 1'b0;
            word_q  <= '0;
          end
          if (st_q == S_DRAIN && pipe_idle) begin
            bat_q <= bat_q + 1'b1;
            if (last_b) begin
              st_q   <= S_IDLE;
              stat_q <= 1'b0;
            end else if (pend_q | bus.act_in_req) begin
              st_q    <= S_BURST;
              rd_en_q <= 1'b1;
              pend_q  <= 1'b0;
            end else begin
              st_q <= S_ARMED;
            end
          end
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign bus.act_in_vld  = pipe_q[RD_LAT];
  assign bus.act_in      = act_q;
  assign bus.src_rd_en   = rd_en_q;
  assign bus.src_rd_addr = addr_q;
  assign status_feed     = stat_q;
  assign err_flag        = err_q;

`ifdef SBLK_ACT_FEED_STALL_CNT_EN
  logic [15:0] stall_q;

  // Saturating count of ungranted BURST cycles.
  always_ff @(posedge clk_l) begin
    if (!rst_n || cfg_en)
      stall_q <= '0;
    else if (st_q == S_BURST && !bus.src_gnt
             && stall_q != 16'hFFFF)
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_sblk_act_feeder.sv
// Bench for sblk_act_feeder: address-stream scoreboard,
// vector table, random configs and corner sequences.
module tb_sblk_act_feeder;

  logic        clk_l = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b0;
  logic [2:0]  cfg_n_tn = '0;
  logic [1:0]  cfg_n_tp = '0;
  logic [5:0]  cfg_n_batch = '0;
  logic [11:0] cfg_base_addr = '0;
  logic        status_feed, err_flag;
`ifdef SBLK_ACT_FEED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  sblk_act_feeder_if bus();

  sblk_act_feeder dut (
    .clk_l        (clk_l),
    .rst_n        (rst_n),
    .cfg_en       (cfg_en),
    .cfg_n_tn     (cfg_n_tn),
    .cfg_n_tp     (cfg_n_tp),
    .cfg_n_batch  (cfg_n_batch),
    .cfg_base_addr(cfg_base_addr),
    .bus          (bus),
    .status_feed  (status_feed),
    .err_flag     (err_flag)
`ifdef SBLK_ACT_FEED_STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clk_l = ~clk_l;

  int cyc = 0;
  always @(posedge clk_l) cyc <= cyc + 1;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // SRAM model: two-cycle read latency, junk when idle.
  logic        sv0 = 1'b0, sv1 = 1'b0;
  logic [11:0] sa0 = '0, sa1 = '0;
  always @(posedge clk_l) begin
    sv0 <= bus.src_rd_en & bus.src_gnt;
    sa0 <= bus.src_rd_addr;
    sv1 <= sv0;
    sa1 <= sa0;
  end
  assign bus.src_rd_data = sv1 ? {4'hC, sa1} : 16'hBEEF;

  // Reference: the ordered list of addresses whose data
  // must appear on act_in, one per valid cycle.
  logic [11:0] exp_q[$];
  int          vq[$];
  int          rx_cnt = 0;
  bit          mon_on = 1'b0;

  always @(negedge clk_l) begin
    if (mon_on) begin
      if (bus.act_in_vld) begin
        vq.push_back(cyc);
        rx_cnt++;
        if (exp_q.size() == 0) begin
          chk("extra_vld", 1, 0);
        end else begin
          logic [11:0] a;
          a = exp_q.pop_front();
          chk("act_word", 32'(bus.act_in),
              32'({4'hC, a}));
        end
      end else begin
        chk("idle_zero", 32'(bus.act_in), 0);
      end
    end
  end

  // Grant driver: 0 always, 1 = 1,0,0,1.. after req,
  // 2 = random (first burst cycle always granted).
  int gmode = 0;
  int req_cyc = -100;
  always @(negedge clk_l) begin
    int j;
    j = cyc - req_cyc - 1;
    case (gmode)
      1:       bus.src_gnt = !(j == 1 || j == 2);
      2:       bus.src_gnt = (j <= 0) ? 1'b1 :
                 ($urandom_range(0, 3) != 0);
      default: bus.src_gnt = 1'b1;
    endcase
  end

  task automatic pulse_req();
    @(negedge clk_l);
    bus.act_in_req = 1'b1;
    req_cyc = cyc;
    @(negedge clk_l);
    bus.act_in_req = 1'b0;
  endtask

  task automatic do_cfg(int tn, int tp, int nb, int base,
                        bit e_err, bit e_stat);
    @(negedge clk_l);
    cfg_n_tn      = 3'(tn);
    cfg_n_tp      = 2'(tp);
    cfg_n_batch   = 6'(nb);
    cfg_base_addr = 12'(base);
    cfg_en        = 1'b1;
    @(negedge clk_l);
    cfg_en = 1'b0;
    chk("cfg_err", 32'(err_flag), 32'(e_err));
    chk("cfg_stat", 32'(status_feed), 32'(e_stat));
  endtask

  task automatic push(int base, int first, int cnt);
    for (int i = 0; i < cnt; i++)
      exp_q.push_back(12'(base + first + i));
  endtask

  task automatic wait_done(int bound);
    int t = 0;
    while (exp_q.size() != 0 && t < bound) begin
      @(posedge clk_l);
      t++;
    end
    chk("words_left", 32'(exp_q.size()), 0);
  endtask

  typedef struct {
    int tn; int tp; int nb; int base;
    int mode; int span; int stall;
  } vec_t;

  task automatic run_vec(vec_t v);
    int L;
    int rc;
    L = v.tn * v.tp * 4;
    gmode = v.mode;
    do_cfg(v.tn, v.tp, v.nb, v.base, 0, 1);
    for (int b = 0; b < v.nb; b++) begin
      vq.delete();
      rx_cnt = 0;
      push(v.base, b * L, L);
      pulse_req();
      rc = req_cyc;
      wait_done(40 * L + 50);
      chk("batch_len", 32'(rx_cnt), 32'(L));
      chk("first_lat",
          32'(vq.size() != 0 ? vq[0] - rc : -1), 4);
      if (v.span >= 0)
        chk("span", 32'(vq[$] - vq[0]), 32'(v.span));
      @(negedge clk_l);
      chk("status_after", 32'(status_feed),
          (b == v.nb - 1) ? 0 : 1);
    end
    chk("err_end", 32'(err_flag), 0);
`ifdef SBLK_ACT_FEED_STALL_CNT_EN
    if (v.stall >= 0)
      chk("stall_cnt", 32'(stall_cnt), 32'(v.stall));
`endif
  endtask

  task automatic wait_rx(int n);
    int t = 0;
    while (rx_cnt < n && t < 500) begin
      @(posedge clk_l);
      t++;
    end
    chk("wait_rx", 32'(rx_cnt >= n), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    vec_t rv;
    tbl[0] = '{2, 2, 1, 'h010, 0, 15, 0};
    tbl[1] = '{2, 2, 1, 'h010, 1, 17, 2};
    tbl[2] = '{2, 1, 1, 'hFFC, 0, 7, 0};
    tbl[3] = '{1, 1, 3, 'h100, 0, 3, 0};
    tbl[4] = '{7, 3, 1, 'h7F0, 2, -1, -1};
    tbl[5] = '{3, 2, 2, 'hFF0, 2, -1, -1};

    bus.act_in_req = 1'b0;
    bus.src_gnt    = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_l);
    chk("rst_vld", 32'(bus.act_in_vld), 0);
    chk("rst_act", 32'(bus.act_in), 0);
    chk("rst_rden", 32'(bus.src_rd_en), 0);
    chk("rst_addr", 32'(bus.src_rd_addr), 0);
    chk("rst_stat", 32'(status_feed), 0);
    chk("rst_err", 32'(err_flag), 0);
    rst_n  = 1'b1;
    mon_on = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    for (int r = 0; r < 4; r++) begin
      rv.tn    = int'($urandom_range(1, 7));
      rv.tp    = int'($urandom_range(1, 3));
      rv.nb    = int'($urandom_range(1, 3));
      rv.base  = int'($urandom_range(0, 4095));
      rv.mode  = 2;
      rv.span  = -1;
      rv.stall = -1;
      run_vec(rv);
    end

    // Pending requests chain three batches back to back.
    gmode = 0;
    do_cfg(2, 2, 3, 'h200, 0, 1);
    vq.delete();
    rx_cnt = 0;
    push('h200, 0, 48);
    pulse_req();
    repeat (4) @(negedge clk_l);
    pulse_req();
    wait_rx(20);
    pulse_req();
    wait_done(400);
    chk("pend_total", 32'(rx_cnt), 48);
    chk("pend_gap0", 32'(vq[16] - vq[15]), 4);
    chk("pend_gap1", 32'(vq[32] - vq[31]), 4);
    @(negedge clk_l);
    chk("pend_stat", 32'(status_feed), 0);
    chk("pend_err", 32'(err_flag), 0);

    // Request in IDLE, double pending, beyond n_batch.
    pulse_req();
    chk("idle_req_err", 32'(err_flag), 1);
    do_cfg(2, 2, 3, 'h400, 0, 1);
    rx_cnt = 0;
    push('h400, 0, 32);
    pulse_req();
    pulse_req();
    chk("pend_ok", 32'(err_flag), 0);
    pulse_req();
    chk("pend_ovf", 32'(err_flag), 1);
    wait_done(400);
    repeat (8) @(negedge clk_l);
    chk("ovf_words", 32'(rx_cnt), 32);
    chk("ovf_stat", 32'(status_feed), 1);
    do_cfg(1, 1, 1, 'h500, 0, 1);
    rx_cnt = 0;
    push('h500, 0, 4);
    pulse_req();
    pulse_req();
    chk("over_nb_err", 32'(err_flag), 1);
    wait_done(100);
    @(negedge clk_l);
    chk("over_nb_stat", 32'(status_feed), 0);
    chk("over_nb_words", 32'(rx_cnt), 4);
    do_cfg(2, 0, 1, 'h600, 1, 0);

    // Reconfigure after five words of a burst.
    do_cfg(2, 2, 1, 'h300, 0, 1);
    rx_cnt = 0;
    push('h300, 0, 16);
    pulse_req();
    begin
      int t = 0;
      while (rx_cnt < 5 && t < 100) begin
        @(negedge clk_l);
        #1;
        t++;
      end
    end
    cfg_n_tn      = 3'd1;
    cfg_n_tp      = 2'd1;
    cfg_n_batch   = 6'd1;
    cfg_base_addr = 12'h050;
    cfg_en        = 1'b1;
    exp_q.delete();
    @(negedge clk_l);
    cfg_en = 1'b0;
    repeat (6) @(negedge clk_l);
    chk("abort_words", 32'(rx_cnt), 5);
    chk("abort_stat", 32'(status_feed), 1);
    chk("abort_err", 32'(err_flag), 0);
    rx_cnt = 0;
    push('h050, 0, 4);
    pulse_req();
    wait_done(100);
    chk("abort_new", 32'(rx_cnt), 4);

    // Reset in the middle of a burst.
    do_cfg(2, 2, 1, 'h700, 0, 1);
    push('h700, 0, 16);
    pulse_req();
    repeat (4) @(negedge clk_l);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk_l);
    chk("mrst_vld", 32'(bus.act_in_vld), 0);
    chk("mrst_act", 32'(bus.act_in), 0);
    chk("mrst_rden", 32'(bus.src_rd_en), 0);
    chk("mrst_addr", 32'(bus.src_rd_addr), 0);
    chk("mrst_stat", 32'(status_feed), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk_l);
    chk("mrst_idle", 32'(status_feed), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
